mips_main_control: RTL and testbench
====================================

# mips_main_control

Multicycle MIPS main control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback. It consumes the instruction opcode and the ALU zero flag and produces every datapath enable and mux select, including the 2-bit ALUop consumed by ALUControl. It sits between the instruction register and the datapath.

## Interface
Parameters:
- none; encodings are fixed in the shared package.

Ports:
- clk_i  in  1  the single clock; all state changes occur on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- opcode_i  in  6  instr[31:26] from the instruction register.
- zero_i  in  1  ALU zero flag, used in the BRANCH state.
- ALUop_o  out  2  00 = add, 01 = subtract, 10 = decode from funct.
- alusrca_o  out  1  0 = PC, 1 = register A.
- alusrcb_o  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- iord_o  out  1  memory address: 0 = PC, 1 = ALUOut.
- irwrite_o  out  1  instruction register load enable.
- memwrite_o  out  1  data memory write enable.
- regwrite_o  out  1  register file write enable.
- regdst_o  out  1  destination register: 0 = rt, 1 = rd.
- memtoreg_o  out  1  writeback source: 0 = ALUOut, 1 = memory data.
- pcsrc_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen_o  out  1  PC enable = pcwrite | (branch & zero_i).
- illegal_o  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and the outputs asserted in each (everything not listed is 0):
  - FETCH: irwrite, alusrcb=01, pcwrite. Always goes to DECODE.
  - DECODE: alusrcb=11. Goes to MEMADR (lw/sw), EXECUTE (R-type), BRANCH (beq), ADDIEX (addi) or JUMP (j). Any other opcode asserts illegal_o and goes to FETCH.
  - MEMADR: alusrca, alusrcb=10. Goes to MEMRD (lw) or MEMWR (sw).
  - MEMRD: iord. Goes to MEMWB.
  - MEMWB: regwrite, memtoreg. Goes to FETCH.
  - MEMWR: iord, memwrite. Goes to FETCH.
  - EXECUTE: alusrca, ALUop=10. Goes to ALUWB.
  - ALUWB: regdst, regwrite. Goes to FETCH.
  - BRANCH: alusrca, ALUop=01, pcsrc=01, branch. Goes to FETCH.
  - ADDIEX: alusrca, alusrcb=10. Goes to ADDIWB.
  - ADDIWB: regwrite. Goes to FETCH.
  - JUMP: pcsrc=10, pcwrite. Goes to FETCH.
- Outputs are decoded from the state register only (Moore). The one exception is pcen_o, which is combinational in zero_i during BRANCH.
- In MEMADR, opcode_i is re-sampled; the instruction register is stable because irwrite is 0 outside FETCH.

## Timing
- Reset: state = FETCH asynchronously. While rst_n_i is low, irwrite_o, memwrite_o, regwrite_o, pcen_o and illegal_o are forced to 0. All other outputs show their FETCH values.
- The first FETCH after reset release performs its writes on the first rising edge of clk_i that occurs with rst_n_i high.
- Cycles per instruction, FETCH to FETCH exclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset asserted mid-instruction aborts it immediately; no partial writes occur after the assertion.
- zero_i is ignored outside BRANCH.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - ALUop encodings (ALU_ADD, ALU_SUB, ALU_FUNCT);
  - alusrcb and pcsrc encodings;
  - a packed control-word struct.
- Sub-module mips_ctrl_outdec: a purely combinational state-to-control-word decoder. The top level holds the state register, the next-state logic, the pcen gating and the reset masking.

## Test plan
- Reset held for 3 cycles, then released with opcode 100011: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite_o=1 and memtoreg_o=1 only in cycle 5.
- opcode 000000: ALUop_o=10 exactly in EXECUTE; regdst_o=1 and regwrite_o=1 in ALUWB; 4 cycles total.
- opcode 000100 with zero_i=1, then 0: in BRANCH, ALUop_o=01 and pcsrc_o=01; pcen_o=1 then 0; 3 cycles each.
- opcode 101011, then 001000: memwrite_o=1 and iord_o=1 in cycle 4 of sw; addi runs 4 cycles with alusrcb_o=10 in ADDIEX and regwrite_o=1 with regdst_o=0 in ADDIWB.
- opcode 111111: illegal_o pulses for 1 cycle in DECODE, then FETCH; no write enable is asserted in that instruction except FETCH's irwrite and pcwrite.
- rst_n_i pulled low asynchronously mid-MEMWR: memwrite_o drops immediately with no clock edge needed, and the state is FETCH after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit.
// Holds the FSM state enum, opcode values, ALUop / alusrcb / pcsrc
// encodings, the packed control word and an opcode-support helper.
package mips_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned SRCB_W   = 2;
  localparam int unsigned PCSRC_W  = 2;
  localparam int unsigned STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 2'b10;

  localparam logic [SRCB_W-1:0] SRCB_B      = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control word produced by the state decoder.
  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrca;
    logic [SRCB_W-1:0]  alusrcb;
    logic               iord;
    logic               irwrite;
    logic               memwrite;
    logic               regwrite;
    logic               regdst;
    logic               memtoreg;
    logic [PCSRC_W-1:0] pcsrc;
    logic               pcwrite;
    logic               branch;
  } ctrl_t;

  // True for every opcode the control unit sequences.
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decoder (Moore outputs).
// Ports:
//   state  in   current FSM state
//   ctrl   out  datapath control word for that state
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Every field defaults to 0; each state raises only its own controls.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control unit: Moore FSM sequencing
// fetch / decode / execute / memory / writeback.
// Ports:
//   clk_i, rst_n_i         clock, async active-low reset
//   opcode_i[5:0]          instr[31:26] from the instruction register
//   zero_i                 ALU zero flag (used only in BRANCH)
//   ALUop_o[1:0]           00 add, 01 sub, 10 funct
//   alusrca_o, alusrcb_o   ALU operand selects
//   iord_o                 memory address select
//   irwrite_o, memwrite_o, regwrite_o   write enables (masked in reset)
//   regdst_o, memtoreg_o   register file destination / data selects
//   pcsrc_o[1:0]           next-PC select
//   pcen_o                 PC enable = pcwrite | (branch & zero_i)
//   illegal_o              pulse in DECODE on an unsupported opcode
module mips_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  output logic [1:0] ALUop_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic       iord_o,
  output logic       irwrite_o,
  output logic       memwrite_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic [1:0] pcsrc_o,
  output logic       pcen_o,
  output logic       illegal_o
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_FETCH;
    else          state <= state_next;
  end

  // Next-state logic; opcode_i is re-read in MEMADR since IR is held.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode_i == OP_LW)      state_next = S_MEMRD;
        else if (opcode_i == OP_SW) state_next = S_MEMWR;
        else                        state_next = S_FETCH;
      end
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // Select outputs pass straight through from the decoded control word.
  assign ALUop_o    = ctrl.aluop;
  assign alusrca_o  = ctrl.alusrca;
  assign alusrcb_o  = ctrl.alusrcb;
  assign iord_o     = ctrl.iord;
  assign regdst_o   = ctrl.regdst;
  assign memtoreg_o = ctrl.memtoreg;
  assign pcsrc_o    = ctrl.pcsrc;

  // Side-effecting enables are gated by reset so an abort takes effect
  // the instant rst_n_i falls, without waiting for a clock edge.
  assign irwrite_o  = rst_n_i & ctrl.irwrite;
  assign memwrite_o = rst_n_i & ctrl.memwrite;
  assign regwrite_o = rst_n_i & ctrl.regwrite;
  assign pcen_o     = rst_n_i & (ctrl.pcwrite | (ctrl.branch & zero_i));
  assign illegal_o  = rst_n_i & (state == S_DECODE) & ~op_supported(opcode_i);

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: cycle-by-cycle vector table,
// an asynchronous mid-instruction reset sequence, and randomized
// instruction streams checked against an instruction-level model.
module tb_mips_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

  mips_main_control dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .opcode_i   (opcode),
    .zero_i     (zero),
    .ALUop_o    (aluop),
    .alusrca_o  (alusrca),
    .alusrcb_o  (alusrcb),
    .iord_o     (iord),
    .irwrite_o  (irwrite),
    .memwrite_o (memwrite),
    .regwrite_o (regwrite),
    .regdst_o   (regdst),
    .memtoreg_o (memtoreg),
    .pcsrc_o    (pcsrc),
    .pcen_o     (pcen),
    .illegal_o  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // Observed outputs packed in a fixed order for whole-word compares.
  logic [14:0] act;
  assign act = {aluop, alusrca, alusrcb, iord, irwrite, memwrite, regwrite,
                regdst, memtoreg, pcsrc, pcen, illegal};

  function automatic logic [14:0] cw(input logic [1:0] a_op, input logic a_a,
                                     input logic [1:0] a_b, input logic i_d,
                                     input logic irw, input logic mw,
                                     input logic rw, input logic rd,
                                     input logic m2r, input logic [1:0] pcs,
                                     input logic pe, input logic ill);
    return {a_op, a_a, a_b, i_d, irw, mw, rw, rd, m2r, pcs, pe, ill};
  endfunction

  task automatic check(input string name, input logic [14:0] got,
                       input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] op, input logic z,
                     input logic [14:0] exp, input string name);
    vec_t v;
    v.op = op; v.z = z; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  // Instruction-level model: length and which cycle carries each write.
  function automatic int model_len(input logic [5:0] op);
    case (op)
      LW:           return 5;
      SW, RT, ADDI: return 4;
      BEQ, JMP:     return 3;
      default:      return 2;
    endcase
  endfunction

  // Returns {irwrite, memwrite, regwrite, pcen, illegal} for cycle k.
  function automatic logic [4:0] model_bits(input logic [5:0] op, input int k,
                                            input logic z);
    int   n;
    logic legal, irw, mw, rw, pe, ill;
    n     = model_len(op);
    legal = (op == LW) || (op == SW) || (op == RT) || (op == BEQ) ||
            (op == ADDI) || (op == JMP);
    irw = (k == 0);
    mw  = (op == SW) && (k == 3);
    rw  = ((op == LW) || (op == RT) || (op == ADDI)) && (k == n - 1);
    pe  = (k == 0) || ((op == JMP) && (k == 2)) || ((op == BEQ) && (k == 2) && z);
    ill = !legal && (k == 1);
    return {irw, mw, rw, pe, ill};
  endfunction

  logic [14:0] w_fetch, w_decode, w_reset;

  initial begin
    w_fetch  = cw(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    w_decode = cw(2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    w_reset  = cw(2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // lw
    add(LW, 1'b0, w_fetch, "lw_fetch");
    add(LW, 1'b1, w_decode, "lw_decode");
    add(LW, 1'b1, cw(2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0), "lw_memadr");
    add(LW, 1'b0, cw(2'b00,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0), "lw_memrd");
    add(LW, 1'b1, cw(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0), "lw_memwb");
    // R-type
    add(RT, 1'b0, w_fetch, "r_fetch");
    add(RT, 1'b0, w_decode, "r_decode");
    add(RT, 1'b1, cw(2'b10,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0), "r_execute");
    add(RT, 1'b0, cw(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0), "r_aluwb");
    // beq taken
    add(BEQ, 1'b1, w_fetch, "beq1_fetch");
    add(BEQ, 1'b1, w_decode, "beq1_decode");
    add(BEQ, 1'b1, cw(2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0), "beq1_branch");
    // beq not taken
    add(BEQ, 1'b0, w_fetch, "beq0_fetch");
    add(BEQ, 1'b0, w_decode, "beq0_decode");
    add(BEQ, 1'b0, cw(2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0), "beq0_branch");
    // sw
    add(SW, 1'b1, w_fetch, "sw_fetch");
    add(SW, 1'b0, w_decode, "sw_decode");
    add(SW, 1'b0, cw(2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0), "sw_memadr");
    add(SW, 1'b1, cw(2'b00,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0), "sw_memwr");
    // addi
    add(ADDI, 1'b0, w_fetch, "addi_fetch");
    add(ADDI, 1'b0, w_decode, "addi_decode");
    add(ADDI, 1'b1, cw(2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0), "addi_ex");
    add(ADDI, 1'b0, cw(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0), "addi_wb");
    // j
    add(JMP, 1'b0, w_fetch, "j_fetch");
    add(JMP, 1'b1, w_decode, "j_decode");
    add(JMP, 1'b0, cw(2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,1'b0), "j_jump");
    // illegal
    add(BAD, 1'b1, w_fetch, "ill_fetch");
    add(BAD, 1'b1, cw(2'b00,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1), "ill_decode");
    add(LW, 1'b0, w_fetch, "after_ill_fetch");

    // Reset held for three cycles with lw presented.
    rst_n  = 1'b0;
    opcode = LW;
    zero   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", act, w_reset);
      step();
    end
    rst_n = 1'b1;
    zero  = 1'b0;

    // Cycle-by-cycle table; the final row lands on FETCH without advancing.
    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].op;
      zero   = tbl[i].z;
      @(negedge clk);
      check(tbl[i].name, act, tbl[i].exp);
      if (i != tbl.size() - 1) step();
    end
    step();

    // sw interrupted by reset in MEMWR: DECODE, MEMADR, then MEMWR.
    opcode = SW;
    zero   = 1'b0;
    step();
    step();
    @(negedge clk);
    check1("abort_memwr_before", memwrite, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("abort_memwr_drop", memwrite, 1'b0);
    check("abort_reset_word", act, w_reset);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_fetch_after", act, w_fetch);
    step();
    @(negedge clk);
    check("abort_decode_after", act, w_decode);
    step();
    step();
    @(negedge clk);
    check1("abort_sw_rerun_memwr", memwrite, 1'b1);
    step();

    // Randomized instruction stream against the instruction-level model.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int         sel;
      int         len;
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP)
            op = BAD;
        end
      endcase
      opcode = op;
      len    = model_len(op);
      for (int k = 0; k < len; k++) begin
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("rand_enables", {10'b0, irwrite, memwrite, regwrite, pcen, illegal},
              {10'b0, model_bits(op, k, zero)});
        step();
      end
    end

    // Stream must have ended on an instruction boundary.
    @(negedge clk);
    check("rand_end_fetch", act, w_fetch);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
